// File: rtl/cam_match_scanner.sv
// Serial CAM match-line scanner: walks the 32:1 match mux, hands each
// asserted line out over valid/ready and reports the hit total on done.
module cam_match_scanner #(
  parameter int SEL_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 first_only,
  input  logic                 abort,
  output logic [SEL_WIDTH-1:0] mux_sel,
  input  logic                 mux_line,
  output logic                 hit_valid,
  input  logic                 hit_ready,
  output logic [SEL_WIDTH-1:0] hit_index,
  output logic                 busy,
  output logic                 done,
  output logic [SEL_WIDTH:0]   hit_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [SEL_WIDTH-1:0] SEL_LAST = '1;
  localparam logic [SEL_WIDTH-1:0] SEL_ONE  = {{(SEL_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SEL_WIDTH:0]   CNT_ONE  = {{SEL_WIDTH{1'b0}}, 1'b1};

  state_t                 r_state;
  logic [SEL_WIDTH-1:0]   r_sel;
  logic                   r_valid;
  logic [SEL_WIDTH-1:0]   r_index;
  logic                   r_busy;
  logic                   r_done;
  logic [SEL_WIDTH:0]     r_count;
  logic                   r_first;

  wire w_last = (r_sel == SEL_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_index <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
      r_first <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort && r_state != IDLE) begin
        // abort beats a same-cycle accept; hit_count is left as is
        r_state <= IDLE;
        r_sel   <= '0;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_sel <= '0;
            if (start) begin
              r_state <= SCAN;
              r_busy  <= 1'b1;
              r_count <= '0;
              r_first <= first_only;
            end
          end
          SCAN: begin
            if (mux_line) begin
              r_state <= HOLD;
              r_valid <= 1'b1;
              r_index <= r_sel;
            end else if (w_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_sel <= r_sel + SEL_ONE;
            end
          end
          HOLD: begin
            if (hit_ready) begin
              r_valid <= 1'b0;
              r_count <= r_count + CNT_ONE;
              if (r_first || w_last) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= SCAN;
                r_sel   <= r_sel + SEL_ONE;
              end
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mux_sel   = r_sel;
  assign hit_valid = r_valid;
  assign hit_index = r_index;
  assign busy      = r_busy;
  assign done      = r_done;
  assign hit_count = r_count;

endmodule

// File: tb/tb_cam_match_scanner.sv
// Directed + random bench for cam_match_scanner; the bench plays the
// match-line mux and checks against a hit-list/latency model.
module tb_cam_match_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        first_only;
  logic        abort;
  logic [4:0]  mux_sel;
  logic        mux_line;
  logic        hit_valid;
  logic        hit_ready;
  logic [4:0]  hit_index;
  logic        busy;
  logic        done;
  logic [5:0]  hit_count;
  logic [31:0] match;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mux_line = match[mux_sel];

  cam_match_scanner #(.SEL_WIDTH(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .first_only (first_only),
    .abort      (abort),
    .mux_sel    (mux_sel),
    .mux_line   (mux_line),
    .hit_valid  (hit_valid),
    .hit_ready  (hit_ready),
    .hit_index  (hit_index),
    .busy       (busy),
    .done       (done),
    .hit_count  (hit_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete scan. stall_fix < 0 picks a random 0..3 stall per hit.
  task automatic run_scan(input logic [31:0] lines, input logic fo,
                          input int stall_fix, input logic poke_done);
    int q[$];
    int scanned, hold_acc, nacc, stall, waited, cyc;
    int cur;
    bit in_hold, done_seen;
    for (int i = 0; i < 32; i++)
      if (lines[i]) q.push_back(i);
    if (fo && q.size() > 1) q = q[0:0];
    scanned  = (fo && q.size() > 0) ? q[0] + 1 : 32;
    hold_acc = 0;
    nacc     = 0;
    stall    = 0;
    waited   = 0;
    cur      = 0;
    in_hold  = 0;
    done_seen = 0;
    match      = lines;
    first_only = fo;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    first_only = $urandom_range(0, 1);
    cyc = 1;
    while (!done_seen && cyc < 400) begin
      if (busy !== 1'b1) check("busy_in_scan", busy, 1);
      if (hit_valid === 1'b1) begin
        if (!in_hold) begin
          cur = (nacc < q.size()) ? q[nacc] : -1;
          check("hit_index", hit_index, cur);
          check("hit_cycle", cyc, cur + 2 + hold_acc);
          in_hold = 1;
          stall   = (stall_fix < 0) ? $urandom_range(0, 3) : stall_fix;
          waited  = 0;
        end else begin
          check("hit_index_stable", hit_index, cur);
        end
        check("hold_mux_sel", mux_sel, cur);
        hit_ready = (waited == stall);
        waited++;
        if (hit_ready) begin
          nacc++;
          in_hold  = 0;
          hold_acc += stall + 1;
        end
      end else begin
        hit_ready = $urandom_range(0, 1);
      end
      if (done === 1'b1) begin
        done_seen = 1;
        check("done_cycle", cyc, scanned + hold_acc + 1);
        check("hit_count", hit_count, q.size());
        check("accepts", nacc, q.size());
        if (poke_done) start = 1'b1;
      end
      tick();
      cyc++;
    end
    if (!done_seen) check("done_timeout", 0, 1);
    start = 1'b0;
    hit_ready = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_count", hit_count, q.size());
    if (poke_done) begin
      tick();
      check("poke_ignored", busy, 0);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    first_only = 1'b0;
    abort = 1'b0;
    hit_ready = 1'b0;
    match = '0;
    tick();
    tick();
    check("rst_state", {26'd0, mux_sel, hit_valid}, 0);
    check("rst_regs", {19'd0, hit_index, busy, done, hit_count}, 0);
    reset = 1'b0;
    tick();

    run_scan(32'h0000_0000, 1'b0, 0, 1'b0);
    run_scan(32'h8000_0001, 1'b0, 0, 1'b0);
    run_scan(32'h0000_0020, 1'b0, 5, 1'b0);
    run_scan(32'h0000_0F00, 1'b1, 0, 1'b0);
    run_scan(32'hFFFF_FFFF, 1'b0, 0, 1'b1);
    for (int r = 0; r < 6; r++)
      run_scan($urandom & $urandom, 1'($urandom_range(0, 1)), -1, 1'b0);

    // abort in HOLD racing an accept: first hit kept, second dropped
    match = 32'h0000_0009;
    first_only = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (hit_valid !== 1'b1 && n < 50) begin tick(); n++; end
    check("abort_hit0", hit_index, 0);
    hit_ready = 1'b1;
    tick();
    hit_ready = 1'b0;
    n = 0;
    while (hit_valid !== 1'b1 && n < 50) begin tick(); n++; end
    check("abort_hit3", hit_index, 3);
    hit_ready = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    hit_ready = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", hit_valid, 0);
    check("abort_sel", mux_sel, 0);
    check("abort_count", hit_count, 1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1 || busy === 1'b1) n++;
      tick();
    end
    check("abort_quiet", n, 0);

    // synchronous reset in the middle of a scan
    match = 32'h0000_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("pre_rst_sel", mux_sel, 10);
    reset = 1'b1;
    tick();
    check("mid_rst_state", {26'd0, mux_sel, hit_valid}, 0);
    check("mid_rst_regs", {19'd0, hit_index, busy, done, hit_count}, 0);
    reset = 1'b0;
    tick();
    run_scan(32'h0010_0400, 1'b0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
